// File: rtl/count_pkg.sv
// count_pkg: shared 3-bit value constants and the checker FSM encoding.
package count_pkg;
    localparam logic [2:0] V0 = 3'd0;
    localparam logic [2:0] V1 = 3'd1;
    localparam logic [2:0] V2 = 3'd2;
    localparam logic [2:0] V3 = 3'd3;
    localparam logic [2:0] V4 = 3'd4;
    localparam logic [2:0] V5 = 3'd5;
    localparam logic [2:0] V6 = 3'd6;
    localparam logic [2:0] V7 = 3'd7;
    localparam logic [2:0] HOLD_VAL = V6;
    localparam logic [2:0] ILLEGAL_VAL = V7;
    typedef enum logic [1:0] {SYNC, TRACK, HOLD} state_t;
endpackage

// File: rtl/count_next_lut.sv
// count_next_lut: legal successor of a counter sample given the inorder input that produced it.
module count_next_lut
    import count_pkg::*;
(
    input  logic [2:0] i_c,
    input  logic       i_inorder,
    output logic [2:0] o_next,
    output logic       o_enter_hold
);
    always_comb begin
        case (i_c)
            V0: o_next = V1;
            V1: o_next = i_inorder ? V2 : V4;
            V2: o_next = i_inorder ? V3 : V5;
            V3: o_next = i_inorder ? V4 : V6;
            V4: o_next = i_inorder ? V5 : V2;
            V5: o_next = i_inorder ? V6 : V3;
            V6: o_next = i_inorder ? V6 : V1;
            // an illegal 7 has no successor; restart the prediction at 0
            default: o_next = V0;
        endcase
    end
    assign o_enter_hold = (i_c == HOLD_VAL) && i_inorder;
endmodule

// File: rtl/count_checker.sv
// count_checker: predicts each counter sample from the previous one and flags, counts and records deviations.
module count_checker
    import count_pkg::*;
#(
    parameter int ERR_W = 8,
    parameter int HIST_D = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          count,
    input  logic                inorder,
    input  logic                clear,
    output logic                err_pulse,
    output logic                err_sticky,
    output logic [ERR_W-1:0]    err_count,
    output logic [6:0]          seen,
    output logic [3*HIST_D-1:0] history,
    output logic                tracking
);
    state_t     r_state;
    logic [2:0] r_exp;
    logic [2:0] w_lut_next;
    logic [2:0] w_expect;
    logic [6:0] w_seen_bit;
    logic       w_enter_hold;
    logic       w_err;

    count_next_lut u_lut (
        .i_c          (count),
        .i_inorder    (inorder),
        .o_next       (w_lut_next),
        .o_enter_hold (w_enter_hold)
    );

    assign w_expect   = r_state == SYNC ? V0 : r_state == HOLD ? HOLD_VAL : r_exp;
    assign w_err      = count == ILLEGAL_VAL || count != w_expect;
    assign w_seen_bit = count == ILLEGAL_VAL ? 7'd0 : 7'd1 << count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= SYNC;
            r_exp      <= V0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            seen       <= '0;
            history    <= '0;
            tracking   <= 1'b0;
        end else begin
            err_pulse  <= w_err;
            err_sticky <= !clear && (err_sticky || w_err);
            err_count  <= clear ? '0 : (w_err && !(&err_count)) ? err_count + 1'b1 : err_count;
            seen       <= clear ? '0 : seen | w_seen_bit;
            history    <= {history[3*HIST_D-4:0], count};
            tracking   <= 1'b1;
            // a mismatch resynchronises on the observed sample and never enters HOLD
            r_state    <= (!w_err && r_state == TRACK && w_enter_hold) ? HOLD : TRACK;
            r_exp      <= (!w_err && r_state == HOLD) ? V1 : w_lut_next;
        end
    end
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: directed and randomized checks of count_checker against a sequence-level model.
module tb_count_checker;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  count = 3'd0;
    logic        inorder = 1'b0;
    logic        clear = 1'b0;
    logic        err_pulse, err_sticky, tracking;
    logic [7:0]  err_count;
    logic [6:0]  seen;
    logic [11:0] history;
    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    count_checker dut (
        .clock      (clock),
        .reset      (reset),
        .count      (count),
        .inorder    (inorder),
        .clear      (clear),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .seen       (seen),
        .history    (history),
        .tracking   (tracking)
    );

    bit          m_valid = 0, m_first = 1, m_hold = 0, m_after = 0;
    bit          m_pulse = 0, m_sticky = 0, m_track = 0;
    int          m_pc = 0, m_pi = 0, m_cnt = 0;
    logic [6:0]  m_seen = '0;
    logic [11:0] m_hist = '0;

    function automatic int nxt(input int c, input int i);
        case (c)
            0: return 1;
            1: return i ? 2 : 4;
            2: return i ? 3 : 5;
            3: return i ? 4 : 6;
            4: return i ? 5 : 2;
            5: return i ? 6 : 3;
            6: return i ? 6 : 1;
            default: return 0;
        endcase
    endfunction

    function automatic int expected();
        return m_first ? 0 : m_after ? 1 : nxt(m_pc, m_pi);
    endfunction

    function automatic bit bad();
        return count == 3'd7 || int'(count) != expected();
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_valid <= 1; m_first <= 1; m_hold <= 0; m_after <= 0;
            m_pulse <= 0; m_sticky <= 0; m_cnt <= 0; m_seen <= '0;
            m_hist <= '0; m_track <= 0; m_pc <= 0; m_pi <= 0;
        end else if (m_valid) begin
            m_pulse  <= bad();
            m_sticky <= clear ? 1'b0 : (m_sticky | bad());
            m_cnt    <= clear ? 0 : (bad() && m_cnt < 255) ? m_cnt + 1 : m_cnt;
            m_seen   <= clear ? 7'd0 : (count == 3'd7 ? m_seen : m_seen | (7'd1 << count));
            m_hist   <= {m_hist[8:0], count};
            m_track  <= 1;
            m_first  <= 0;
            m_pc     <= int'(count);
            m_pi     <= int'(inorder);
            m_hold   <= !bad() && !m_hold && count == 3'd6 && inorder;
            m_after  <= !bad() && m_hold;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            check("err_pulse", 32'(err_pulse), 32'(m_pulse));
            check("err_sticky", 32'(err_sticky), 32'(m_sticky));
            check("err_count", 32'(err_count), 32'(m_cnt));
            check("seen", 32'(seen), 32'(m_seen));
            check("history", 32'(history), 32'(m_hist));
            check("tracking", 32'(tracking), 32'(m_track));
        end
    end

    task automatic step(input int c, input bit i, input bit cl = 0, input bit rs = 0);
        count = 3'(c);
        inorder = i;
        clear = cl;
        reset = rs;
        @(posedge clock);
        #2;
    endtask

    int seq1[8] = '{1, 2, 3, 4, 5, 6, 6, 1};
    int seq2[8] = '{0, 1, 4, 2, 5, 3, 6, 1};

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_tracking", 32'(tracking), 0);
        check("rst_history", 32'(history), 0);
        check("rst_count", 32'(err_count), 0);
        step(0, 1);
        check("sync_tracking", 32'(tracking), 1);
        foreach (seq1[k]) step(seq1[k], 1);
        check("seq1_seen", 32'(seen), 32'h7f);
        check("seq1_errs", 32'(err_count), 0);

        step(0, 0, 0, 1);
        foreach (seq2[k]) step(seq2[k], 0);
        check("seq2_hist", 32'(history[5:0]), 32'o61);
        check("seq2_errs", 32'(err_count), 0);

        step(0, 0, 0, 1);
        for (int v = 0; v < 4; v++) step(v, 1);
        step(6, 0);
        check("seq3_pulse", 32'(err_pulse), 1);
        check("seq3_count", 32'(err_count), 1);
        step(1, 0);
        check("seq3_no_second", 32'(err_pulse), 0);
        check("seq3_count_hold", 32'(err_count), 1);

        repeat (300) step(7, 1'($urandom % 2));
        check("sat_count", 32'(err_count), 255);
        check("sat_sticky", 32'(err_sticky), 1);

        step(0, 0, 0, 1);
        step(3, 1);
        check("sync_err_pulse", 32'(err_pulse), 1);
        check("sync_err_count", 32'(err_count), 1);
        step(5, 0, 1);
        check("clr_count", 32'(err_count), 0);
        check("clr_sticky", 32'(err_sticky), 0);
        check("clr_pulse", 32'(err_pulse), 1);

        step(0, 0, 0, 1);
        for (int v = 0; v < 7; v++) step(v, 1);
        step(2, 0, 0, 1);
        check("hold_rst_tracking", 32'(tracking), 0);
        check("hold_rst_seen", 32'(seen), 0);
        check("hold_rst_hist", 32'(history), 0);
        step(0, 0);
        check("hold_rst_zero_ok", 32'(err_pulse), 0);

        repeat (3000) begin
            int e;
            e = expected();
            step(($urandom % 8) < 7 ? e : int'($urandom % 8), 1'($urandom % 2),
                 ($urandom % 40) == 0, ($urandom % 100) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
